// File: rtl/alu_exec_if.sv
// Handshake/operand bundle between the decode/operand-mux stage, the ALU
// execute unit and the writeback/branch logic.
//   in_valid/in_ready   : request handshake (operands + control code)
//   alu_ctrl            : 4-bit operation code from the ALU control decoder
//   op_a/op_b           : operands; op_b low bits carry the shift amount
//   out_valid/out_ready : result handshake
//   result/zero         : registered result and its zero flag
// master = upstream/downstream side driving requests and consuming results,
// slave  = the execute unit.
interface alu_exec_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output in_valid, alu_ctrl, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, alu_ctrl, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute unit. Logic/arithmetic ops and SLT finish at the
// accept edge; shifts iterate one bit position per cycle instead of using a
// barrel shifter.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; aborts any operation in flight
//   bus   : alu_exec_if slave modport (in_valid/in_ready, alu_ctrl, op_a,
//           op_b, out_valid/out_ready, result, zero)
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic       clk,
    input  logic       reset,
    alu_exec_if.slave  bus
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1000;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t               state;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic [WIDTH-1:0]     result_r;
    logic                 zero_r;
    logic [WIDTH-1:0]     shift_reg;
    logic [SHAMT_W-1:0]   shamt_cnt;
    logic [3:0]           shift_code;

    logic [WIDTH-1:0]     alu_res;
    logic [WIDTH-1:0]     shift_next;
    logic [SHAMT_W-1:0]   shamt_in;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == OP_SLL) || (code == OP_SRL) || (code == OP_SRA);
    endfunction

    // Single-cycle ops. Shift codes never reach this path; they fall to 0.
    function automatic logic [WIDTH-1:0] alu_op(input logic [3:0] code,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] a_s;
        logic signed [WIDTH-1:0] b_s;
        a_s = a;
        b_s = b;
        case (code)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLT:  return {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            default: return '0;
        endcase
    endfunction

    // One bit position of the iterative shifter.
    function automatic logic [WIDTH-1:0] shift_one(input logic [3:0] code,
                                                   input logic [WIDTH-1:0] v);
        logic signed [WIDTH-1:0] v_s;
        v_s = v;
        case (code)
            OP_SLL:  return v << 1;
            OP_SRL:  return v >> 1;
            OP_SRA:  return v_s >>> 1;
            default: return v;
        endcase
    endfunction

    always_comb begin
        alu_res    = alu_op(bus.alu_ctrl, bus.op_a, bus.op_b);
        shift_next = shift_one(shift_code, shift_reg);
        shamt_in   = bus.op_b[SHAMT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= '0;
            zero_r      <= 1'b1;
            shift_reg   <= '0;
            shamt_cnt   <= '0;
            shift_code  <= OP_ADD;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_r <= 1'b0;
                        if (!is_shift(bus.alu_ctrl)) begin
                            result_r    <= alu_res;
                            zero_r      <= (alu_res == '0);
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end else if (shamt_in == '0) begin
                            result_r    <= bus.op_a;
                            zero_r      <= (bus.op_a == '0);
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end else begin
                            shift_reg  <= bus.op_a;
                            shamt_cnt  <= shamt_in;
                            shift_code <= bus.alu_ctrl;
                            state      <= SHIFT;
                        end
                    end
                end

                SHIFT: begin
                    shift_reg <= shift_next;
                    shamt_cnt <= shamt_cnt - 1'b1;
                    // Last bit position: publish the shifted value directly
                    // so out_valid rises exactly shamt cycles after accept.
                    if (shamt_cnt == SHAMT_W'(1)) begin
                        result_r    <= shift_next;
                        zero_r      <= (shift_next == '0);
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end

                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.zero      = zero_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with a result scoreboard queue.
module tb_alu_exec_unit;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;

    logic [32:0] sb[$];   // {zero, result}

    alu_exec_if #(.WIDTH(32)) bus ();

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [3:0] c,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << b[4:0];
            4'd6: return a >> b[4:0];
            4'd7: return $signed(a) >>> b[4:0];
            4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Push expectation, issue one op, measure latency, compare, complete.
    task automatic run_op(input string tag, input logic [3:0] c,
                          input logic [31:0] a, input logic [31:0] b);
        logic [32:0] e;
        int lat;
        int exp_lat;
        logic [31:0] r;
        r = model(c, a, b);
        sb.push_back({(r == 32'd0), r});
        exp_lat = (c == 4'd5 || c == 4'd6 || c == 4'd7) ? int'(b[4:0]) : 0;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.alu_ctrl = c;
        bus.op_a     = a;
        bus.op_b     = b;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op_a     = $urandom();
        bus.op_b     = $urandom();
        bus.alu_ctrl = 4'($urandom());
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
        e = sb.pop_front();
        check({tag, "_result"}, bus.result, e[31:0]);
        check({tag, "_zero"}, 32'(bus.zero), 32'(e[32]));
        @(negedge clk);
        check({tag, "_out_valid_clr"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_ready_again"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [32:0] e;
        logic        seen;
        n_vec  = 0;
        n_miss = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.alu_ctrl  = 4'd0;
        bus.op_a      = 32'd0;
        bus.op_b      = 32'd0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_zero", 32'(bus.zero), 32'd1);
        reset = 1'b0;

        run_op("add_5_7",    4'd0, 32'd5, 32'd7);
        run_op("sub_3_5",    4'd1, 32'd3, 32'd5);
        run_op("sub_9_9",    4'd1, 32'd9, 32'd9);
        run_op("and",        4'd2, 32'hF0F0_1234, 32'h0FF0_FF00);
        run_op("or",         4'd3, 32'hF000_0001, 32'h000F_0010);
        run_op("sra_4",      4'd7, 32'h8000_0000, 32'd4);
        run_op("srl_4",      4'd6, 32'h8000_0000, 32'd4);
        run_op("sll_5",      4'd5, 32'd1, 32'h25);
        run_op("sll_0",      4'd5, 32'h0000_ABCD, 32'd0);
        run_op("sll_31",     4'd5, 32'd3, 32'd31);
        run_op("sra_1",      4'd7, 32'hC000_0003, 32'd1);
        run_op("slt_neg",    4'd8, 32'hFFFF_FFFF, 32'd1);
        run_op("slt_swap",   4'd8, 32'd1, 32'hFFFF_FFFF);
        run_op("code_f",     4'hF, 32'h1234_5678, 32'h9ABC_DEF0);

        // Back-pressure: result held, new requests ignored.
        bus.out_ready = 1'b0;
        sb.push_back({1'b0, model(4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00)});
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.alu_ctrl = 4'd4;
        bus.op_a     = 32'hF0F0_F0F0;
        bus.op_b     = 32'hFF00_FF00;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_result", bus.result, sb[0][31:0]);
            bus.in_valid = ~bus.in_valid;
            bus.alu_ctrl = 4'($urandom());
            bus.op_a     = $urandom();
            bus.op_b     = $urandom();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        e = sb.pop_front();
        check("bp_result_final", bus.result, e[31:0]);
        check("bp_zero_final", 32'(bus.zero), 32'(e[32]));
        @(negedge clk);
        check("bp_released", 32'(bus.out_valid), 32'd0);

        // Reset mid-shift: operation aborted, nothing stale emerges.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.alu_ctrl = 4'd5;
        bus.op_a     = 32'd1;
        bus.op_b     = 32'd20;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("shift_busy_out_valid", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_result", bus.result, 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_zero", 32'(bus.zero), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        check("abort_no_stale", 32'(seen), 32'd0);

        run_op("add_after_rst", 4'd0, 32'd1, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
